// File: rtl/gray_pkg.sv
// gray_pkg: shared types, constants and Gray decode for Gray-code consumers
package gray_pkg;
    typedef enum logic [1:0] {FILL, ACQ, TRACK} state_e;
    localparam int ERR_CNT_W  = 8;
    localparam int GRAY_MAX_W = 32;
    // Widest supported decode; callers zero-extend an N-bit code and truncate the result,
    // which is exact because leading zero Gray bits decode to leading zero binary bits.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: STAGES-deep, N-bit synchronizer chain with async reset
// clk/rst: clock and async active-high reset; gray_in: raw code; gray_out: last stage
module gray_sync #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] gray_out
);
    logic [STAGES-1:0][N-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], gray_in};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end
    assign gray_out = sync_q[STAGES-1];
endmodule

// File: rtl/gray_rx_monitor.sv
// gray_rx_monitor: synchronizes and decodes a Gray count, checks each transition for a single forward step
// clk/rst: clock, async active-high reset; gray_in: upstream Gray count; clr_err: clears err_cnt
// bin_out/bin_valid: last accepted binary count; step/wrap/err: one-cycle event pulses; err_cnt: saturating error count
module gray_rx_monitor
    import gray_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         gray_in,
    input  logic                 clr_err,
    output logic [N-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 step,
    output logic                 wrap,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [N-1:0]         sync_gray, cur, diff;
    state_e               state_q, state_d;
    logic [2:0]           fill_q, fill_d;
    logic [N-1:0]         bin_out_q, bin_out_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_q, step_d, wrap_q, wrap_d, err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    gray_sync #(.N(N), .STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .gray_out (sync_gray)
    );

    assign cur  = N'(gray2bin(GRAY_MAX_W'(sync_gray)));
    assign diff = cur - bin_out_q;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            FILL: begin
                fill_d  = fill_q + 1'b1;
                state_d = (fill_q == 3'(SYNC_STAGES - 1)) ? ACQ : FILL;
            end
            ACQ: begin
                bin_out_d   = cur;
                bin_valid_d = 1'b1;
                state_d     = TRACK;
            end
            TRACK: begin
                // any non-unit distance, including a backward step, resynchronizes to cur
                bin_out_d = cur;
                step_d    = diff == N'(1);
                wrap_d    = step_d && (&bin_out_q);
                err_d     = diff > N'(1);
            end
            default: state_d = FILL;
        endcase
        err_cnt_d = clr_err ? '0 : (err_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            fill_q      <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign step      = step_q;
    assign wrap      = wrap_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_rx_monitor.sv
// tb_gray_rx_monitor: directed self-checking bench for gray_rx_monitor
module tb_gray_rx_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic [3:0] bin_out;
    logic       bin_valid, step, wrap, err;
    logic [7:0] err_cnt;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    gray_rx_monitor #(.N(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step      (step),
        .wrap      (wrap),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    function automatic logic [3:0] b2g(input int i);
        logic [3:0] b;
        b = 4'(i);
        return b ^ (b >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reacquire(input logic [3:0] g);
        rst = 1'b1;
        gray_in = g;
        clr_err = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        tick;
        tick;
    endtask

    task automatic test_reset;
        logic exp_v;
        rst = 1'b1;
        gray_in = 4'b0110;
        clr_err = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_vec++;
            if ({bin_out, bin_valid, step, wrap, err, err_cnt} !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h required 0", {bin_out, bin_valid, step, wrap, err, err_cnt});
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick;
            exp_v = (e >= 3);
            n_vec++;
            if (bin_valid !== exp_v) begin
                n_bad++;
                $display("FAIL reset_valid edge %0d: got %b required %b", e, bin_valid, exp_v);
            end
            if (e >= 3) begin
                n_vec++;
                if (bin_out !== 4'd4) begin
                    n_bad++;
                    $display("FAIL reset_acq edge %0d: got %0d required 4", e, bin_out);
                end
            end
            n_vec++;
            if ({step, err} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_pulses edge %0d: got step=%b err=%b required 0", e, step, err);
            end
        end
    endtask

    task automatic test_count;
        int   wraps;
        logic [3:0] exp_b;
        logic exp_s, exp_w, exp_v;
        wraps = 0;
        rst = 1'b1;
        gray_in = 4'd0;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            gray_in = b2g(i);
            tick;
            exp_v = (i >= 2);
            exp_b = (i >= 2) ? 4'((i - 2) % 16) : 4'd0;
            exp_s = (i >= 3);
            exp_w = (i == 18);
            wraps += int'(wrap);
            n_vec++;
            if ({bin_valid, bin_out} !== {exp_v, exp_b}) begin
                n_bad++;
                $display("FAIL count_bin i=%0d: got v=%b %0d required v=%b %0d", i, bin_valid, bin_out, exp_v, exp_b);
            end
            n_vec++;
            if ({step, wrap, err} !== {exp_s, exp_w, 1'b0}) begin
                n_bad++;
                $display("FAIL count_pulses i=%0d: got s/w/e=%b%b%b required %b%b0", i, step, wrap, err, exp_s, exp_w);
            end
        end
        n_vec++;
        if (wraps != 1 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL count_totals: got wraps=%0d err_cnt=%0d required 1 and 0", wraps, err_cnt);
        end
    endtask

    task automatic test_jump;
        reacquire(4'b0001);
        gray_in = 4'b0110;
        tick;
        tick;
        tick;
        n_vec++;
        if ({err, step, bin_out, err_cnt} !== {1'b1, 1'b0, 4'd4, 8'd1}) begin
            n_bad++;
            $display("FAIL jump_err: got err=%b step=%b bin=%0d cnt=%0d required 1 0 4 1", err, step, bin_out, err_cnt);
        end
        gray_in = 4'b0111;
        tick;
        tick;
        tick;
        n_vec++;
        if ({err, step, bin_out, err_cnt} !== {1'b0, 1'b1, 4'd5, 8'd1}) begin
            n_bad++;
            $display("FAIL jump_step: got err=%b step=%b bin=%0d cnt=%0d required 0 1 5 1", err, step, bin_out, err_cnt);
        end
    endtask

    task automatic test_backward_hold;
        reacquire(4'b0011);
        gray_in = 4'b0001;
        tick;
        tick;
        tick;
        n_vec++;
        if ({err, step, wrap, bin_out, err_cnt} !== {3'b100, 4'd1, 8'd1}) begin
            n_bad++;
            $display("FAIL backward: got e/s/w=%b%b%b bin=%0d cnt=%0d required 100 1 1", err, step, wrap, bin_out, err_cnt);
        end
        for (int c = 0; c < 5; c++) begin
            tick;
            n_vec++;
            if ({err, step, wrap, bin_out} !== {3'b000, 4'd1}) begin
                n_bad++;
                $display("FAIL hold c=%0d: got e/s/w=%b%b%b bin=%0d required 000 1", c, err, step, wrap, bin_out);
            end
        end
    endtask

    task automatic test_saturate_clear;
        int errs;
        errs = 0;
        reacquire(4'b0000);
        for (int i = 0; i < 260; i++) begin
            gray_in = i[0] ? 4'b0000 : 4'b0110;
            tick;
            errs += int'(err);
            if (i == 101) begin
                n_vec++;
                if (err_cnt !== 8'd100) begin
                    n_bad++;
                    $display("FAIL sat_mid: got %0d required 100", err_cnt);
                end
            end
        end
        tick;
        errs += int'(err);
        tick;
        errs += int'(err);
        n_vec++;
        if (errs != 260 || err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_end: got errs=%0d cnt=%0d required 260 255", errs, err_cnt);
        end
        gray_in = 4'b0110;
        tick;
        tick;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        n_vec++;
        if ({err, bin_out, err_cnt} !== {1'b1, 4'd4, 8'd0}) begin
            n_bad++;
            $display("FAIL clear_wins: got err=%b bin=%0d cnt=%0d required 1 4 0", err, bin_out, err_cnt);
        end
        gray_in = 4'b0000;
        tick;
        tick;
        tick;
        n_vec++;
        if ({err, err_cnt} !== {1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL after_clear: got err=%b cnt=%0d required 1 1", err, err_cnt);
        end
    endtask

    task automatic test_midstream_reset;
        logic exp_v;
        reacquire(4'b0000);
        for (int i = 1; i <= 11; i++) begin
            gray_in = b2g(i);
            tick;
        end
        n_vec++;
        if ({bin_out, step} !== {4'd9, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_pre: got bin=%0d step=%b required 9 1", bin_out, step);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bin_out, bin_valid, step, wrap, err, err_cnt} !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_async_clear: got %h required 0", {bin_out, bin_valid, step, wrap, err, err_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick;
            exp_v = (e >= 3);
            n_vec++;
            if ({err, step, bin_valid} !== {2'b00, exp_v}) begin
                n_bad++;
                $display("FAIL mid_reacq edge %0d: got err=%b step=%b v=%b required 0 0 %b", e, err, step, bin_valid, exp_v);
            end
            if (e >= 3) begin
                n_vec++;
                if (bin_out !== 4'd11) begin
                    n_bad++;
                    $display("FAIL mid_reacq_bin edge %0d: got %0d required 11", e, bin_out);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_count;
        test_jump;
        test_backward_hold;
        test_saturate_clear;
        test_midstream_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
